// File: rtl/triangle_assembler.sv
`timescale 1ns/1ps
// Assembles a vertex stream into list or strip triangles and presents one buffered triangle to the rasterizer.
// Latency: 1 cycle from acceptance of a triangle's third vertex to tri_ready.
// Backpressure: while a triangle is held and rast_rfd=0, vtx_rfd=0. vtx_rfd follows rast_rfd combinationally, so strips sustain one triangle per cycle.
//
// Ports:
//   clk, rst                  clock (rising edge) and asynchronous active-low reset
//   vtx_nd/vtx_rfd/vtx_data   vertex handshake and attribute bundle (posX in the LSBs)
//   vtx_restart               accepted vertex starts a new primitive
//   strip_mode                0 = list, 1 = strip; sampled on a primitive's first vertex
//   tri_ready/rast_rfd        triangle handshake towards the rasterizer
//   v1/v2/v3_data             registered triangle vertex bundles, with strip winding corrected
//   tri_count                 count of transferred triangles, wraps at 16 bits
// Optional feature macro: TRI_DEGEN_CULL_EN drops triangles whose (posX,posY) pairs coincide.

module triangle_assembler #(
  parameter int ATTR_W = 16,
  parameter int N_ATTR = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vtx_nd,
  input  logic                       vtx_restart,
  input  logic [ATTR_W*N_ATTR-1:0]   vtx_data,
  output logic                       vtx_rfd,
  input  logic                       strip_mode,
  output logic                       tri_ready,
  input  logic                       rast_rfd,
  output logic [ATTR_W*N_ATTR-1:0]   v1_data,
  output logic [ATTR_W*N_ATTR-1:0]   v2_data,
  output logic [ATTR_W*N_ATTR-1:0]   v3_data,
  output logic [15:0]                tri_count
);

  localparam int VW = ATTR_W * N_ATTR;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_strip;      // mode of the primitive in progress
  logic            r_parity;     // strip triangle index is odd
  logic            r_tri_ready;
  logic [15:0]     r_tri_count;
  // The two most recently accepted vertices in stream order (r_p1 newest).
  // In a strip these are exactly the two vertices the next triangle reuses.
  logic [VW-1:0]   r_p0;
  logic [VW-1:0]   r_p1;
  logic [VW-1:0]   r_v1;
  logic [VW-1:0]   r_v2;
  logic [VW-1:0]   r_v3;

  logic            w_xfer;
  logic            w_vtx_rfd;
  logic            w_vtx_acc;
  logic            w_first;
  logic            w_odd;
  logic            w_cull;
  state_t          w_base;
  logic [VW-1:0]   w_t1;
  logic [VW-1:0]   w_t2;

  assign w_xfer    = r_tri_ready & rast_rfd;
  // Gated by rst so the producer never sees a ready while the block is held in reset.
  assign w_vtx_rfd = rst & ((r_state != S_FULL) | rast_rfd);
  assign w_vtx_acc = vtx_nd & w_vtx_rfd;

  // State as it would be after this cycle's transfer, before any vertex is applied.
  // A strip keeps its last two vertices; a list starts over.
  always_comb begin
    w_base = r_state;
    if (w_xfer) begin
      w_base = r_strip ? S_TWO : S_EMPTY;
    end
  end

  // The accepted vertex opens a new primitive: explicit restart or nothing held.
  assign w_first = vtx_restart | (w_base == S_EMPTY);

  // Odd strip triangles swap the first two vertices to keep a consistent winding.
  assign w_odd = r_strip & r_parity;
  assign w_t1  = w_odd ? r_p1 : r_p0;
  assign w_t2  = w_odd ? r_p0 : r_p1;

`ifdef TRI_DEGEN_CULL_EN
  // Degenerate when any two vertices share the same (posX,posY) bit pattern.
  logic [2*ATTR_W-1:0] w_pos0;
  logic [2*ATTR_W-1:0] w_pos1;
  logic [2*ATTR_W-1:0] w_pos2;
  assign w_pos0 = r_p0[2*ATTR_W-1:0];
  assign w_pos1 = r_p1[2*ATTR_W-1:0];
  assign w_pos2 = vtx_data[2*ATTR_W-1:0];
  assign w_cull = (w_pos0 == w_pos1) | (w_pos1 == w_pos2) | (w_pos0 == w_pos2);
`else
  assign w_cull = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_strip     <= 1'b0;
      r_parity    <= 1'b0;
      r_tri_ready <= 1'b0;
      r_tri_count <= 16'h0000;
      r_p0        <= '0;
      r_p1        <= '0;
      r_v1        <= '0;
      r_v2        <= '0;
      r_v3        <= '0;
    end else begin
      if (w_xfer) begin
        r_tri_count <= r_tri_count + 16'h0001;
      end

      if (w_vtx_acc) begin
        r_p0 <= r_p1;
        r_p1 <= vtx_data;
      end

      if (w_vtx_acc) begin
        if (w_first) begin
          r_state     <= S_ONE;
          r_strip     <= strip_mode;
          r_parity    <= 1'b0;
          r_tri_ready <= 1'b0;
        end else if (w_base == S_ONE) begin
          r_state     <= S_TWO;
          r_tri_ready <= 1'b0;
        end else begin
          // Third vertex completes a triangle (base can only be TWO here).
          // Lists keep parity at zero; strips advance it even for culled triangles.
          r_parity <= r_strip & ~r_parity;
          if (w_cull) begin
            r_state     <= r_strip ? S_TWO : S_EMPTY;
            r_tri_ready <= 1'b0;
          end else begin
            r_state     <= S_FULL;
            r_tri_ready <= 1'b1;
            r_v1        <= w_t1;
            r_v2        <= w_t2;
            r_v3        <= vtx_data;
          end
        end
      end else begin
        r_state     <= w_base;
        r_tri_ready <= (w_base == S_FULL);
      end
    end
  end

  assign vtx_rfd   = w_vtx_rfd;
  assign tri_ready = r_tri_ready;
  assign v1_data   = r_v1;
  assign v2_data   = r_v2;
  assign v3_data   = r_v3;
  assign tri_count = r_tri_count;

endmodule

// File: tb/tb_triangle_assembler.sv
`timescale 1ns/1ps
module tb_triangle_assembler;

  localparam int ATTR_W = 16;
  localparam int N_ATTR = 9;
  localparam int VW     = ATTR_W * N_ATTR;

  logic            clk = 1'b0;
  logic            rst;
  logic            vtx_nd;
  logic            vtx_restart;
  logic [VW-1:0]   vtx_data;
  logic            vtx_rfd;
  logic            strip_mode;
  logic            tri_ready;
  logic            rast_rfd;
  logic [VW-1:0]   v1_data;
  logic [VW-1:0]   v2_data;
  logic [VW-1:0]   v3_data;
  logic [15:0]     tri_count;

  always #5 clk = ~clk;

  triangle_assembler #(.ATTR_W(ATTR_W), .N_ATTR(N_ATTR)) dut (
    .clk(clk), .rst(rst), .vtx_nd(vtx_nd), .vtx_restart(vtx_restart),
    .vtx_data(vtx_data), .vtx_rfd(vtx_rfd), .strip_mode(strip_mode),
    .tri_ready(tri_ready), .rast_rfd(rast_rfd), .v1_data(v1_data),
    .v2_data(v2_data), .v3_data(v3_data), .tri_count(tri_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Vertex id -> attribute bundle. Ids differing only in bit 7 share posX/posY.
  function automatic logic [VW-1:0] vtx_of(input logic [7:0] id);
    logic [VW-1:0] v;
    logic [7:0]    pid;
    pid = {1'b0, id[6:0]};
    for (int i = 0; i < N_ATTR; i++) v[i*ATTR_W +: ATTR_W] = {id, 8'(i)};
    v[ATTR_W-1:0]        = {pid, 8'h00};
    v[2*ATTR_W-1:ATTR_W] = {pid, 8'h01};
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [VW-1:0] m_prim[$];   // vertices of the current primitive still needed
  int            m_k;         // strip index of the next triangle
  bit            m_strip;
  bit            m_full;
  logic [VW-1:0] m_v1, m_v2, m_v3;
  logic [15:0]   m_cnt;

  task automatic model_reset();
    m_prim.delete();
    m_k = 0; m_strip = 0; m_full = 0; m_cnt = 16'h0000;
    m_v1 = '0; m_v2 = '0; m_v3 = '0;
  endtask

  task automatic model_emit(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c);
    bit degen;
    degen = (a[31:0] == b[31:0]) || (b[31:0] == c[31:0]) || (a[31:0] == c[31:0]);
`ifdef TRI_DEGEN_CULL_EN
    if (degen) return;
`endif
    m_full = 1; m_v1 = a; m_v2 = b; m_v3 = c;
  endtask

  task automatic model_vertex(input bit rs, input bit sm, input logic [VW-1:0] d);
    if (rs || m_prim.size() == 0) begin
      m_prim.delete(); m_k = 0; m_strip = sm;
    end
    m_prim.push_back(d);
    if (m_prim.size() == 3) begin
      if (!m_strip) begin
        model_emit(m_prim[0], m_prim[1], m_prim[2]);
        m_prim.delete();
      end else begin
        if (m_k % 2 == 0) model_emit(m_prim[0], m_prim[1], m_prim[2]);
        else              model_emit(m_prim[1], m_prim[0], m_prim[2]);
        void'(m_prim.pop_front());
        m_k++;
      end
    end
  endtask

  task automatic step(input bit nd, input bit rs, input bit sm, input logic [VW-1:0] d, input bit rr);
    bit e_rfd, acc, xfer;
    @(negedge clk);
    vtx_nd = nd; vtx_restart = rs; strip_mode = sm; vtx_data = d; rast_rfd = rr;
    #1;
    e_rfd = !m_full || rr;
    chk("m_vtx_rfd", VW'(vtx_rfd), VW'(e_rfd));
    acc  = nd && e_rfd;
    xfer = m_full && rr;
    @(posedge clk);
    if (xfer) begin m_cnt = m_cnt + 16'h0001; m_full = 0; end
    if (acc) model_vertex(rs, sm, d);
    #1;
    chk("m_tri_ready", VW'(tri_ready), VW'(m_full));
    if (m_full) begin
      chk("m_v1", v1_data, m_v1);
      chk("m_v2", v2_data, m_v2);
      chk("m_v3", v3_data, m_v3);
    end
    chk("m_tri_count", VW'(tri_count), VW'(m_cnt));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit nd; bit rs; bit sm; logic [7:0] id; bit rr;
    bit e_rfd; bit e_rdy; logic [7:0] e1; logic [7:0] e2; logic [7:0] e3; logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input bit nd, input bit rs, input bit sm, input logic [7:0] id, input bit rr,
                     input bit e_rfd, input bit e_rdy, input logic [7:0] e1, input logic [7:0] e2,
                     input logic [7:0] e3, input logic [15:0] e_cnt);
    vec_t r;
    r.nd = nd; r.rs = rs; r.sm = sm; r.id = id; r.rr = rr;
    r.e_rfd = e_rfd; r.e_rdy = e_rdy; r.e1 = e1; r.e2 = e2; r.e3 = e3; r.e_cnt = e_cnt;
    tbl.push_back(r);
  endtask

  initial begin
    rst = 1'b0; vtx_nd = 0; vtx_restart = 0; vtx_data = '0; strip_mode = 0; rast_rfd = 0;
    model_reset();

    // list A..F
    row(1,1,0,8'd1,1, 1,0,0,0,0,0);
    row(1,0,0,8'd2,1, 1,0,0,0,0,0);
    row(1,0,0,8'd3,1, 1,1,1,2,3,0);
    row(1,0,0,8'd4,1, 1,0,0,0,0,1);
    row(1,0,0,8'd5,1, 1,0,0,0,0,1);
    row(1,0,0,8'd6,1, 1,1,4,5,6,1);
    row(0,0,0,8'd0,1, 1,0,0,0,0,2);
    // strip A..E back to back
    row(1,1,1,8'd11,1, 1,0,0,0,0,2);
    row(1,0,1,8'd12,1, 1,0,0,0,0,2);
    row(1,0,1,8'd13,1, 1,1,11,12,13,2);
    row(1,0,1,8'd14,1, 1,1,13,12,14,3);
    row(1,0,1,8'd15,1, 1,1,13,14,15,4);
    row(0,0,1,8'd0,1,  1,0,0,0,0,5);
    // backpressure on a held list triangle
    row(1,1,0,8'd21,0, 1,0,0,0,0,5);
    row(1,0,0,8'd22,0, 1,0,0,0,0,5);
    row(1,0,0,8'd23,0, 1,1,21,22,23,5);
    for (int i = 0; i < 10; i++) row(1,0,0,8'd24,0, 0,1,21,22,23,5);
    row(0,0,0,8'd0,1, 1,0,0,0,0,6);
    row(0,0,0,8'd0,1, 1,0,0,0,0,6);
    // strip restart
    row(1,1,1,8'd31,1, 1,0,0,0,0,6);
    row(1,0,1,8'd32,1, 1,0,0,0,0,6);
    row(1,0,1,8'd33,1, 1,1,31,32,33,6);
    row(1,0,1,8'd34,1, 1,1,33,32,34,7);
    row(1,1,1,8'd35,1, 1,0,0,0,0,8);
    row(1,0,1,8'd36,1, 1,0,0,0,0,8);
    row(1,0,1,8'd37,1, 1,1,35,36,37,8);
    row(0,0,1,8'd0,1,  1,0,0,0,0,9);
    // partial list discarded by restart
    row(1,1,0,8'd41,1, 1,0,0,0,0,9);
    row(1,0,0,8'd42,1, 1,0,0,0,0,9);
    row(1,1,0,8'd43,1, 1,0,0,0,0,9);
    row(1,0,0,8'd44,1, 1,0,0,0,0,9);
    row(1,0,0,8'd45,1, 1,1,43,44,45,9);
    row(0,0,0,8'd0,1,  1,0,0,0,0,10);
    // strip_mode change mid-primitive is ignored
    row(1,1,0,8'd61,1, 1,0,0,0,0,10);
    row(1,0,1,8'd62,1, 1,0,0,0,0,10);
    row(1,0,1,8'd63,1, 1,1,61,62,63,10);
    row(0,0,1,8'd0,1,  1,0,0,0,0,11);
    row(1,0,0,8'd64,1, 1,0,0,0,0,11);
    row(1,0,0,8'd65,1, 1,0,0,0,0,11);
    row(1,0,0,8'd66,1, 1,1,64,65,66,11);
    row(0,0,0,8'd0,1,  1,0,0,0,0,12);
    // degenerate triangle (8'hD1 shares posX/posY with 8'h51)
    row(1,1,0,8'h51,1, 1,0,0,0,0,12);
    row(1,0,0,8'hD1,1, 1,0,0,0,0,12);
`ifdef TRI_DEGEN_CULL_EN
    row(1,0,0,8'h53,1, 1,0,0,0,0,12);
    row(0,0,0,8'd0,1,  1,0,0,0,0,12);
`else
    row(1,0,0,8'h53,1, 1,1,8'h51,8'hD1,8'h53,12);
    row(0,0,0,8'd0,1,  1,0,0,0,0,13);
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tri_ready", VW'(tri_ready), '0);
    chk("rst_vtx_rfd",   VW'(vtx_rfd), '0);
    chk("rst_tri_count", VW'(tri_count), '0);
    chk("rst_v1", v1_data, '0);
    chk("rst_v2", v2_data, '0);
    chk("rst_v3", v3_data, '0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      vtx_nd = tbl[i].nd; vtx_restart = tbl[i].rs; strip_mode = tbl[i].sm;
      vtx_data = vtx_of(tbl[i].id); rast_rfd = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_rfd", i), VW'(vtx_rfd), VW'(tbl[i].e_rfd));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_rdy", i), VW'(tri_ready), VW'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_cnt", i), VW'(tri_count), VW'(tbl[i].e_cnt));
      if (tbl[i].e_rdy) begin
        chk($sformatf("tbl%0d_v1", i), v1_data, vtx_of(tbl[i].e1));
        chk($sformatf("tbl%0d_v2", i), v2_data, vtx_of(tbl[i].e2));
        chk($sformatf("tbl%0d_v3", i), v3_data, vtx_of(tbl[i].e3));
      end
    end

    // async reset while a triangle is held
    @(negedge clk);
    rast_rfd = 0; strip_mode = 0; vtx_nd = 1;
    vtx_restart = 1; vtx_data = vtx_of(8'd71); @(negedge clk);
    vtx_restart = 0; vtx_data = vtx_of(8'd72); @(negedge clk);
    vtx_data = vtx_of(8'd73); @(negedge clk);
    vtx_nd = 0;
    chk("hold_tri_ready", VW'(tri_ready), VW'(1'b1));
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_tri_ready", VW'(tri_ready), '0);
    chk("arst_vtx_rfd",   VW'(vtx_rfd), '0);
    chk("arst_tri_count", VW'(tri_count), '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_tri_ready", VW'(tri_ready), '0);
      chk("post_rst_vtx_rfd",   VW'(vtx_rfd), VW'(1'b1));
    end
    model_reset();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0 ? 1'b1 : 1'b0,
           vtx_of(8'($urandom_range(0, 255))), $urandom_range(0, 9) < 7);
    end

    // long strip to reach the counter wrap
    @(negedge clk); rst = 1'b0; vtx_nd = 0; rast_rfd = 0;
    @(negedge clk); rst = 1'b1;
    model_reset();
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFE; i++) begin
      step(1'b1, i == 0, 1'b1, vtx_of(8'(i)), 1'b1);
    end
    chk("cnt_fffe", VW'(tri_count), VW'(16'hFFFE));
    step(1'b1, 1'b0, 1'b1, vtx_of(8'hA0), 1'b1);
    step(1'b1, 1'b0, 1'b1, vtx_of(8'hA1), 1'b1);
    chk("cnt_wrap", VW'(tri_count), VW'(16'h0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
